// File: rtl/operand_seq_pkg.sv
// Shared widths, state encoding and slot constants for the operand sequencer.
package operand_seq_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned OPERAND_W = 12;
  localparam int unsigned SLOT_W    = 3;

  typedef logic [2:0] state_t;

  localparam state_t LOAD_A = 3'd0;
  localparam state_t LOAD_B = 3'd1;
  localparam state_t CALC   = 3'd2;
  localparam state_t CAPT   = 3'd3;
  localparam state_t HOLD   = 3'd4;

  localparam logic [SLOT_W-1:0] SLOT_W1_MSN = 3'd0;
  localparam logic [SLOT_W-1:0] SLOT_W2_MSN = 3'd3;

  function automatic logic is_load(input state_t s);
    return (s == LOAD_A) || (s == LOAD_B);
  endfunction

endpackage

// File: rtl/operand_seq_if.sv
// Bus between the sequencer and its neighbours: keypad events, datapath, result handshake.
interface operand_seq_if
  import operand_seq_pkg::*;
();

  logic                 key_valid;
  logic [NIB_W-1:0]     key_code;
  logic                 clear;
  logic [NIB_W-1:0]     sample;
  logic                 sample_we;
  logic [SLOT_W-1:0]    slot;
  logic                 calc;
  logic [OPERAND_W-1:0] sum_in;
  logic [OPERAND_W-1:0] result;
  logic                 res_valid;
  logic                 res_ready;
  logic                 busy;
  logic                 timeout;

  // Sequencer side
  modport master (
    input  key_valid, key_code, clear, sum_in, res_ready,
    output sample, sample_we, slot, calc, result, res_valid, busy, timeout
  );

  // Keypad, datapath and display side
  modport slave (
    output key_valid, key_code, clear, sum_in, res_ready,
    input  sample, sample_we, slot, calc, result, res_valid, busy, timeout
  );

endinterface

// File: rtl/operand_seq_entry_timeout.sv
// Idle counter for partial operand entry; expired pulses for one cycle at TIMEOUT_CYC-1.
module entry_timeout #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart || expired || !enable) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/operand_seq.sv
// Operand entry sequencer for the nibble-serial 12-bit adder.
// The entry timeout is built only when OPERAND_SEQ_TIMEOUT_EN is defined.
module operand_seq
  import operand_seq_pkg::*;
#(
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic          clk,
  input  logic          n_reset,
  operand_seq_if.master bus
);

  localparam logic [SLOT_W-1:0] IdxLastA = SLOT_W'(DIGITS - 1);
  localparam logic [SLOT_W-1:0] IdxLastB = SLOT_W'(2 * DIGITS - 1);

  state_t               state_q, state_d;
  logic [SLOT_W-1:0]    idx_q, idx_d;
  logic [NIB_W-1:0]     sample_q;
  logic                 sample_we_q;
  logic [SLOT_W-1:0]    slot_q;
  logic                 calc_q;
  logic [OPERAND_W-1:0] result_q;
  logic                 res_valid_q;
  logic                 timeout_q;

  logic in_load;
  logic expired;
  logic abort;
  logic key_acc;

  assign in_load = is_load(state_q);

`ifdef OPERAND_SEQ_TIMEOUT_EN
  entry_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_entry_timeout (
    .clk     (clk),
    .n_reset (n_reset),
    .restart (bus.key_valid && in_load),
    .enable  (in_load && (idx_q != SLOT_W1_MSN)),
    .expired (expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign expired = 1'b0;
`endif

  // A timeout abort behaves exactly like clear; clear always wins over a key.
  assign abort   = bus.clear || expired;
  assign key_acc = bus.key_valid && in_load && !abort;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (abort) begin
      state_d = LOAD_A;
      idx_d   = SLOT_W1_MSN;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (key_acc) begin
            idx_d = idx_q + SLOT_W'(1);
            if (idx_q == IdxLastA) begin
              state_d = LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (key_acc) begin
            idx_d = idx_q + SLOT_W'(1);
            if (idx_q == IdxLastB) begin
              state_d = CALC;
              idx_d   = SLOT_W1_MSN;
            end
          end
        end
        // Stay one extra cycle so calc is registered before moving to capture.
        CALC: begin
          if (calc_q) begin
            state_d = CAPT;
          end
        end
        CAPT: begin
          state_d = HOLD;
        end
        HOLD: begin
          if (res_valid_q && bus.res_ready) begin
            state_d = LOAD_A;
            idx_d   = SLOT_W1_MSN;
          end
        end
        default: begin
          state_d = LOAD_A;
          idx_d   = SLOT_W1_MSN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= LOAD_A;
      idx_q       <= SLOT_W1_MSN;
      sample_q    <= '0;
      sample_we_q <= 1'b0;
      slot_q      <= '0;
      calc_q      <= 1'b0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sample_we_q <= key_acc;
      if (key_acc) begin
        sample_q <= bus.key_code;
        slot_q   <= idx_q;
      end
      calc_q    <= (state_q == CALC) && !calc_q && !abort;
      timeout_q <= expired;
      if ((state_q == CAPT) && !abort) begin
        result_q <= bus.sum_in;
      end
      if (abort) begin
        res_valid_q <= 1'b0;
      end else if (state_q == CAPT) begin
        res_valid_q <= 1'b1;
      end else if (res_valid_q && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.sample    = sample_q;
  assign bus.sample_we = sample_we_q;
  assign bus.slot      = slot_q;
  assign bus.calc      = calc_q;
  assign bus.result    = result_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = (state_q == CALC) || (state_q == CAPT) || (state_q == HOLD);
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_operand_seq.sv
// Directed bench for operand_seq with a behavioural nibble-serial adder model.
module tb_operand_seq;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   calc_cnt = 0;
  int   to_cnt = 0;
  int   snap;

`ifdef OPERAND_SEQ_TIMEOUT_EN
  localparam int ExpTimeouts = 1;
  localparam int SlotAfterIdle = 0;
`else
  localparam int ExpTimeouts = 0;
  localparam int SlotAfterIdle = 2;
`endif

  operand_seq_if bus ();

  operand_seq #(
    .DIGITS      (3),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Adder datapath: six nibble slots, sum registered on calc, wraps at 12 bits.
  logic [3:0]  nib_m [6];
  logic [11:0] sum_m = '0;
  assign bus.sum_in = sum_m;

  always @(posedge clk) begin
    if (bus.sample_we && (bus.slot < 3'd6)) nib_m[bus.slot] <= bus.sample;
    if (bus.calc) sum_m <= {nib_m[0], nib_m[1], nib_m[2]} + {nib_m[3], nib_m[4], nib_m[5]};
  end

  always @(negedge clk) begin
    if (bus.calc) calc_cnt++;
    if (bus.timeout) to_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one key on a negedge; after the next negedge the write must be visible.
  task automatic press(input logic [3:0] code, input int exp_slot);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    check_eq("key_we", 32'(bus.sample_we), 32'd1);
    check_eq("key_slot", 32'(bus.slot), 32'(exp_slot));
    check_eq("key_sample", 32'(bus.sample), 32'(code));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.clear     = 1'b0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 6; i++) nib_m[i] = '0;
    #1;
    check_eq("rst_sample", 32'(bus.sample), 32'd0);
    check_eq("rst_we", 32'(bus.sample_we), 32'd0);
    check_eq("rst_slot", 32'(bus.slot), 32'd0);
    check_eq("rst_calc", 32'(bus.calc), 32'd0);
    check_eq("rst_result", 32'(bus.result), 32'd0);
    check_eq("rst_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_timeout", 32'(bus.timeout), 32'd0);
    idle(2);
    n_reset = 1'b1;
    idle(1);

    // res_ready with nothing held does nothing
    bus.res_ready = 1'b1;
    idle(1);
    bus.res_ready = 1'b0;
    check_eq("ready_noval", 32'(bus.res_valid), 32'd0);

    // 0x073 + 0x247 = 0x2BA, back-to-back keys
    snap = calc_cnt;
    press(4'h0, 0);
    press(4'h7, 1);
    press(4'h3, 2);
    press(4'h2, 3);
    press(4'h4, 4);
    press(4'h7, 5);
    check_eq("busy_calc", 32'(bus.busy), 32'd1);
    check_eq("calc_early", 32'(bus.calc), 32'd0);
    idle(1);
    check_eq("calc_pulse", 32'(bus.calc), 32'd1);
    idle(1);
    check_eq("calc_end", 32'(bus.calc), 32'd0);
    check_eq("valid_early", 32'(bus.res_valid), 32'd0);
    idle(1);
    check_eq("res_valid1", 32'(bus.res_valid), 32'd1);
    check_eq("result1", 32'(bus.result), 32'h2BA);
    check_eq("calc_once", 32'(calc_cnt - snap), 32'd1);

    // Back-pressure for 10 cycles
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check_eq("hold_result", 32'(bus.result), 32'h2BA);
      check_eq("hold_valid", 32'(bus.res_valid), 32'd1);
    end
    bus.res_ready = 1'b1;
    idle(1);
    bus.res_ready = 1'b0;
    check_eq("hs_valid_drop", 32'(bus.res_valid), 32'd0);
    check_eq("hs_busy_drop", 32'(bus.busy), 32'd0);
    press(4'h5, 0);
    press(4'h6, 1);
    press(4'h8, 2);

    // clear wins over a simultaneous key
    bus.clear     = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h9;
    idle(1);
    bus.clear     = 1'b0;
    bus.key_valid = 1'b0;
    check_eq("clr_no_we", 32'(bus.sample_we), 32'd0);

    // 0xFFF + 0x001 wraps to 0x000
    press(4'hF, 0);
    press(4'hF, 1);
    press(4'hF, 2);
    press(4'h0, 3);
    press(4'h0, 4);
    press(4'h1, 5);
    idle(3);
    check_eq("res_valid2", 32'(bus.res_valid), 32'd1);
    check_eq("result_wrap", 32'(bus.result), 32'h000);

    // Key in HOLD is dropped
    bus.key_valid = 1'b1;
    bus.key_code  = 4'hA;
    idle(1);
    bus.key_valid = 1'b0;
    check_eq("hold_key_we", 32'(bus.sample_we), 32'd0);
    check_eq("hold_key_res", 32'(bus.result), 32'h000);
    check_eq("hold_key_busy", 32'(bus.busy), 32'd1);
    check_eq("hold_key_val", 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1;
    idle(1);
    bus.res_ready = 1'b0;
    check_eq("hs2_valid", 32'(bus.res_valid), 32'd0);

    // Asynchronous reset mid-entry
    press(4'h9, 0);
    press(4'hC, 1);
    #2 n_reset = 1'b0;
    #1;
    check_eq("arst_we", 32'(bus.sample_we), 32'd0);
    check_eq("arst_slot", 32'(bus.slot), 32'd0);
    check_eq("arst_sample", 32'(bus.sample), 32'd0);
    idle(1);
    n_reset = 1'b1;
    idle(1);

    // Idle partial entry
    snap = to_cnt;
    press(4'h1, 0);
    press(4'h2, 1);
    idle(20);
    check_eq("timeout_cnt", 32'(to_cnt - snap), 32'(ExpTimeouts));
    press(4'h3, SlotAfterIdle);
    bus.clear = 1'b1;
    idle(1);
    bus.clear = 1'b0;
    press(4'h4, 0);
    check_eq("timeout_total", 32'(to_cnt), 32'(ExpTimeouts));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
